// File: rtl/updown_seq_checker.sv
// rtl/updown_seq_checker.sv - passive scoreboard for an up/down counter: reference model, mismatch pulse, error count, loss-of-lock FSM
module updown_seq_checker #(
   parameter int WIDTH    = 4,
   parameter int ERR_W    = 8,
   parameter int MAX_SLIP = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             chk_en,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic             mode,
   input  logic [WIDTH-1:0] Din,
   input  logic [WIDTH-1:0] Qin,
   output logic [WIDTH-1:0] exp_q,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic             lost,
   output logic [1:0]       state_q
);

   typedef enum logic [1:0] {
      TRACK = 2'b00,
      SLIP  = 2'b01,
      LOST  = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic [ERR_W-1:0] ONE_E    = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [3:0]       SLIP_LIM = 4'(MAX_SLIP);

   state_t           state, state_nxt;
   logic [3:0]       consec, consec_nxt;
   logic             active, hit, miss;
   logic [WIDTH-1:0] base, model_nxt;

   // Compare qualification and the counter reference model; a miss re-seeds the model from Qin
   always_comb begin
      active = chk_en & ~clr;
      hit    = (Qin == exp_q);
      miss   = active & ~hit;
      base   = (chk_en && hit) ? exp_q : Qin;
      if (load)
         model_nxt = Din;
      else if (en)
         model_nxt = mode ? (base - ONE_W) : (base + ONE_W);
      else
         model_nxt = base;
   end

   // Model, pulse and error counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q     <= '0;
         mismatch  <= 1'b0;
         err_count <= '0;
      end else begin
         exp_q    <= model_nxt;
         mismatch <= miss;
         if (clr)
            err_count <= '0;
         else if (miss && (err_count != ERR_MAX))
            err_count <= err_count + ONE_E;
      end
   end

   // FSM state and consecutive-miss register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= TRACK;
         consec <= '0;
      end else begin
         state  <= state_nxt;
         consec <= consec_nxt;
      end
   end

   // Next-state: clr wins; with chk_en low everything holds
   always_comb begin
      state_nxt  = state;
      consec_nxt = consec;
      if (clr) begin
         state_nxt  = TRACK;
         consec_nxt = '0;
      end else if (chk_en) begin
         case (state)
            TRACK: begin
               if (!hit) begin
                  consec_nxt = 4'd1;
                  state_nxt  = (SLIP_LIM == 4'd1) ? LOST : SLIP;
               end
            end
            SLIP: begin
               if (hit) begin
                  consec_nxt = '0;
                  state_nxt  = TRACK;
               end else begin
                  consec_nxt = consec + 4'd1;
                  if ((consec + 4'd1) >= SLIP_LIM)
                     state_nxt = LOST;
               end
            end
            LOST: begin
               state_nxt = LOST;
            end
            default: begin
               state_nxt  = TRACK;
               consec_nxt = '0;
            end
         endcase
      end
   end

   // Outputs decoded from the state register only
   always_comb begin
      state_q = state;
      lost    = (state == LOST);
   end

endmodule

// File: tb/tb_updown_seq_checker.sv
// tb/tb_updown_seq_checker.sv - directed self-checking bench for updown_seq_checker
module tb_updown_seq_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       chk_en = 1'b1;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] Din = 4'd0;
   logic [3:0] Qin = 4'd0;
   logic [3:0] exp_q;
   logic       mismatch;
   logic [7:0] err_count;
   logic       lost;
   logic [1:0] state_q;

   logic [3:0] cnt;
   int         n_vec = 0;
   int         n_miss = 0;

   updown_seq_checker #(.WIDTH(4), .ERR_W(8), .MAX_SLIP(3)) dut (
      .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr),
      .en(en), .load(load), .mode(mode), .Din(Din), .Qin(Qin),
      .exp_q(exp_q), .mismatch(mismatch), .err_count(err_count),
      .lost(lost), .state_q(state_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // q is the counter's actual output this cycle; cnt becomes its output after the edge
   task automatic tick(input logic e, input logic l, input logic m, input logic [3:0] d, input logic [3:0] q);
      en = e; load = l; mode = m; Din = d; Qin = q;
      @(posedge clk);
      #1;
      if (l)
         cnt = d;
      else if (e)
         cnt = m ? 4'(q - 4'd1) : 4'(q + 4'd1);
      else
         cnt = q;
   endtask

   task automatic pulse_reset();
      #3 reset = 1'b1;
      #2 reset = 1'b0;
      cnt = 4'd0;
   endtask

   initial begin
      cnt = 4'd0;
      #12;
      check("rst_exp_q", exp_q, 0);
      check("rst_mismatch", mismatch, 0);
      check("rst_err", err_count, 0);
      check("rst_lost", lost, 0);
      check("rst_state", state_q, 0);
      reset = 1'b0;

      // count up 20 cycles, wrap 15->0 is a hit
      for (int k = 1; k <= 20; k++) begin
         tick(1, 0, 0, 4'd0, cnt);
         check("up_exp_q", exp_q, k % 16);
         check("up_mismatch", mismatch, 0);
      end
      check("up_err", err_count, 0);
      check("up_state", state_q, 0);

      // count down 20 cycles, wrap 0->15 is a hit
      pulse_reset();
      for (int k = 1; k <= 20; k++) begin
         tick(1, 0, 1, 4'd0, cnt);
         check("dn_exp_q", exp_q, (16 - (k % 16)) % 16);
         check("dn_mismatch", mismatch, 0);
      end
      tick(0, 1, 0, 4'hF, cnt);
      check("load_exp_q", exp_q, 15);
      for (int k = 1; k <= 5; k++) begin
         tick(1, 0, 0, 4'd0, cnt);
         check("ld_up_exp_q", exp_q, k - 1);
         check("ld_up_mismatch", mismatch, 0);
      end

      // single glitch: counter shows 7 where 5 is expected
      tick(1, 0, 0, 4'd0, cnt);
      check("pre_glitch_exp", exp_q, 5);
      tick(1, 0, 0, 4'd0, 4'd7);
      check("glitch_mismatch", mismatch, 1);
      check("glitch_err", err_count, 1);
      check("glitch_state", state_q, 1);
      check("glitch_resync", exp_q, 8);
      tick(1, 0, 0, 4'd0, cnt);
      check("post_glitch_mismatch", mismatch, 0);
      check("post_glitch_state", state_q, 0);
      check("post_glitch_exp", exp_q, 9);
      check("post_glitch_err", err_count, 1);

      // clr, then three consecutive skips -> LOST
      clr = 1'b1;
      tick(1, 0, 0, 4'd0, cnt);
      clr = 1'b0;
      check("clr1_err", err_count, 0);
      check("clr1_exp", exp_q, 10);
      check("clr1_mismatch", mismatch, 0);
      for (int j = 0; j < 3; j++) begin
         tick(1, 0, 0, 4'd0, 4'(cnt + 4'd1));
         check("slip_mismatch", mismatch, 1);
         check("slip_lost", lost, (j == 2) ? 1 : 0);
      end
      check("lost_err", err_count, 3);
      check("lost_state", state_q, 2);
      check("lost_exp", exp_q, 0);
      tick(1, 0, 0, 4'd0, cnt);
      check("lost_hit_mismatch", mismatch, 0);
      check("lost_sticky", lost, 1);
      check("lost_hit_exp", exp_q, 1);
      clr = 1'b1;
      tick(1, 0, 0, 4'd0, cnt);
      clr = 1'b0;
      check("clr2_err", err_count, 0);
      check("clr2_lost", lost, 0);
      check("clr2_state", state_q, 0);
      check("clr2_exp", exp_q, 2);

      // continuous corruption with a chk_en=0 window
      for (int i = 0; i < 310; i++) begin
         chk_en = !(i >= 100 && i < 110);
         tick(0, 0, 0, 4'd0, (i % 2 == 1) ? 4'h5 : 4'hA);
         if (i == 99) begin
            check("sat_err_100", err_count, 100);
            check("sat_mismatch_on", mismatch, 1);
         end
         if (i == 109) begin
            check("hold_err", err_count, 100);
            check("hold_mismatch", mismatch, 0);
         end
         if (i == 200) check("sat_err_191", err_count, 191);
         if (i == 309) begin
            check("sat_err_255", err_count, 255);
            check("sat_mismatch_end", mismatch, 1);
            check("sat_lost", lost, 1);
         end
      end
      chk_en = 1'b1;

      // reset mid-operation with exp_q=9, err_count=2
      pulse_reset();
      for (int k = 0; k < 4; k++) tick(1, 0, 0, 4'd0, cnt);
      tick(1, 0, 0, 4'd0, 4'(cnt + 4'd1));
      tick(1, 0, 0, 4'd0, 4'(cnt + 4'd1));
      tick(1, 0, 0, 4'd0, cnt);
      check("mid_exp", exp_q, 9);
      check("mid_err", err_count, 2);
      check("mid_state", state_q, 0);
      #3 reset = 1'b1;
      #1;
      check("arst_exp", exp_q, 0);
      check("arst_err", err_count, 0);
      check("arst_mismatch", mismatch, 0);
      check("arst_lost", lost, 0);
      check("arst_state", state_q, 0);
      #1 reset = 1'b0;
      cnt = 4'd0;
      for (int k = 1; k <= 3; k++) begin
         tick(1, 0, 0, 4'd0, cnt);
         check("rel_exp", exp_q, k);
         check("rel_mismatch", mismatch, 0);
      end
      check("rel_err", err_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
